// File: rtl/ws_psum_collector_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ws_psum_collector_pkg
//  Description : Shared systolic-array definitions: array operating modes,
//                partial-sum width derivation and column slice helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package ws_psum_collector_pkg;

    // Array operating mode: weight load or partial-sum (compute) mode
    typedef enum logic {
        SAMODE_WL = 1'b0,
        SAMODE_PS = 1'b1
    } samode_e;

    // Partial sums carry four times the operand word width to absorb growth
    localparam int c_PSUM_PER_WORD = 4;

    // Partial-sum width for a given activation/weight word width
    function automatic int psum_width(input int word_width);
        return word_width * c_PSUM_PER_WORD;
    endfunction

    // Low bit index of column col in a packed row of ps_width-bit columns
    function automatic int col_lo(input int col, input int ps_width);
        return col * ps_width;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ws_row_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : ws_row_fifo
//  Description : Synchronous row FIFO with occupancy count. A push and a pop
//                in the same cycle are both honoured, including when full.
//  Revision    : 1.0 - initial release
// ============================================================================
module ws_row_fifo
    import ws_psum_collector_pkg::*;
#(
    parameter int WIDTH = 128,
    parameter int DEPTH = 8
)(
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           pop_data,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);

    localparam int c_PTRW = $clog2(DEPTH);
    localparam int c_CNTW = $clog2(DEPTH) + 1;
    localparam logic [c_CNTW-1:0] c_CNT_ONE  = c_CNTW'(1);
    localparam logic [c_CNTW-1:0] c_CNT_FULL = c_CNTW'(DEPTH);
    localparam logic [c_PTRW-1:0] c_PTR_ONE  = c_PTRW'(1);

    logic [WIDTH-1:0]  r_mem [DEPTH];
    logic [c_PTRW-1:0] r_wr_ptr;
    logic [c_PTRW-1:0] r_rd_ptr;
    logic [c_CNTW-1:0] r_count;
    logic              w_do_push;
    logic              w_do_pop;

    // A pop frees the slot this cycle, so a full FIFO still accepts a push
    assign w_do_pop  = pop & ~empty;
    assign w_do_push = push & (~full | w_do_pop);

    assign full     = (r_count == c_CNT_FULL);
    assign empty    = (r_count == '0);
    assign count    = r_count;
    assign pop_data = r_mem[r_rd_ptr];

    // Storage array; contents need no reset because empty masks the head
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally modulo DEPTH (power of two); count tracks occupancy
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + c_CNT_ONE;
                2'b01:   r_count <= r_count - c_CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/ws_psum_collector.sv
`default_nettype none
// ============================================================================
//  Module      : ws_psum_collector
//  Description : Samples the skewed partial-sum columns leaving the systolic
//                array, realigns them into whole rows and buffers the rows
//                in a FIFO drained over a valid/ready handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module ws_psum_collector
    import ws_psum_collector_pkg::*;
#(
    parameter int WORDWIDTH  = 8,
    parameter int ARRWIDTH   = 4,
    parameter int ARRHEIGHT  = 4,
    parameter int PSWIDTH    = psum_width(WORDWIDTH),
    parameter int LAT_BASE   = ARRHEIGHT,
    parameter int FIFO_DEPTH = 8
)(
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          in_valid,
    input  logic [PSWIDTH*ARRWIDTH-1:0]   ps_in_vec,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [PSWIDTH*ARRWIDTH-1:0]   out_vec,
    output logic [$clog2(FIFO_DEPTH):0]   count,
    output logic                          idle,
    output logic                          overflow
);

    // Last tap marks the cycle in which every column of a row is aligned
    localparam int c_NTAPS = LAT_BASE + ARRWIDTH - 1;
    localparam int c_ROWW  = PSWIDTH * ARRWIDTH;

    logic [c_NTAPS:1]  r_tag;
    logic [c_NTAPS:0]  w_tap;
    logic [c_ROWW-1:0] w_row;
    logic [c_ROWW-1:0] w_head;
    logic              w_push;
    logic              w_pop;
    logic              w_full;
    logic              w_empty;
    logic              w_drop;
    logic              r_overflow;

    // Tap k is high when a row entered the array k cycles ago; tap 0 is live
    assign w_tap  = {r_tag, in_valid};
    assign w_push = w_tap[c_NTAPS];

    // Row tag shift chain; reset discards every row in flight
    always_ff @(posedge clk) begin
        if (reset) begin
            r_tag <= '0;
        end else begin
            r_tag <= w_tap[c_NTAPS-1:0];
        end
    end

    // Per-column capture and deskew: column c waits ARRWIDTH-1-c registers
    for (genvar c = 0; c < ARRWIDTH; c++) begin : g_col
        if (c == ARRWIDTH - 1) begin : g_direct
            // Last column arrives exactly on the push strobe, no delay needed
            assign w_row[col_lo(c, PSWIDTH) +: PSWIDTH] =
                ps_in_vec[col_lo(c, PSWIDTH) +: PSWIDTH];
        end else begin : g_skew
            localparam int c_DLY = ARRWIDTH - 1 - c;
            logic [PSWIDTH-1:0] r_dsk [c_DLY];

            // First stage samples only on its tap; later stages shift freely
            always_ff @(posedge clk) begin
                if (reset) begin
                    for (int j = 0; j < c_DLY; j++) begin
                        r_dsk[j] <= '0;
                    end
                end else begin
                    if (w_tap[LAT_BASE + c]) begin
                        r_dsk[0] <= ps_in_vec[col_lo(c, PSWIDTH) +: PSWIDTH];
                    end
                    for (int j = 1; j < c_DLY; j++) begin
                        r_dsk[j] <= r_dsk[j-1];
                    end
                end
            end

            assign w_row[col_lo(c, PSWIDTH) +: PSWIDTH] = r_dsk[c_DLY-1];
        end
    end

    assign w_pop  = out_valid & out_ready;
    assign w_drop = w_push & w_full & ~w_pop;

    ws_row_fifo #(
        .WIDTH (c_ROWW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (w_push),
        .push_data (w_row),
        .pop       (w_pop),
        .pop_data  (w_head),
        .count     (count),
        .full      (w_full),
        .empty     (w_empty)
    );

    // Sticky record that a completed row found no room in the FIFO
    always_ff @(posedge clk) begin
        if (reset) begin
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
        end
    end

    // Head is masked while empty so stale storage never leaks out after reset
    assign out_valid = ~w_empty;
    assign out_vec   = w_empty ? '0 : w_head;
    assign overflow  = r_overflow;
    assign idle      = (r_tag == '0) && w_empty;

endmodule
`default_nettype wire

// File: tb/tb_ws_psum_collector.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ws_psum_collector
//  Description : Directed self-checking bench for ws_psum_collector with
//                default parameters (4 columns, LAT_BASE 4, FIFO depth 8).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ws_psum_collector;

    localparam int PSW  = 32;
    localparam int COLS = 4;
    localparam int LAT  = 4;

    logic             clk;
    logic             reset;
    logic             in_valid;
    logic [127:0]     ps_in_vec;
    logic             out_valid;
    logic             out_ready;
    logic [127:0]     out_vec;
    logic [3:0]       count;
    logic             idle;
    logic             overflow;

    int checks = 0;
    int errors = 0;

    ws_psum_collector #(
        .WORDWIDTH  (8),
        .ARRWIDTH   (4),
        .ARRHEIGHT  (4),
        .PSWIDTH    (32),
        .LAT_BASE   (4),
        .FIFO_DEPTH (8)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .ps_in_vec (ps_in_vec),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_vec   (out_vec),
        .count     (count),
        .idle      (idle),
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to just after the next rising edge (start of next cycle)
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected aligned row r: column c = base + 16*r + c
    function automatic logic [127:0] exp_row(input int r, input logic [31:0] base);
        logic [127:0] v;
        for (int c = 0; c < COLS; c++) begin
            v[c*PSW +: PSW] = base + 32'(16*r + c);
        end
        return v;
    endfunction

    // Inputs for cycle k given nrows back-to-back rows entering from cycle t0;
    // columns not due for capture carry 0xDEAD filler
    task automatic drive(input int k, input int t0, input int nrows, input logic [31:0] base);
        int r;
        in_valid = (k >= t0) && (k < t0 + nrows);
        for (int c = 0; c < COLS; c++) begin
            r = k - LAT - c - t0;
            if (r >= 0 && r < nrows) begin
                ps_in_vec[c*PSW +: PSW] = base + 32'(16*r + c);
            end else begin
                ps_in_vec[c*PSW +: PSW] = 32'h0000_DEAD;
            end
        end
    endtask

    task automatic reset_dut();
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        ps_in_vec = '0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset_dut();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        checks++; if (out_vec !== 128'd0) begin errors++; $display("FAIL reset_out_vec: got %h expected 0", out_vec); end
        checks++; if (count !== 4'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", count); end
        checks++; if (idle !== 1'b1) begin errors++; $display("FAIL reset_idle: got %b expected 1", idle); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b expected 0", overflow); end
    endtask

    task automatic test_single();
        reset_dut();
        for (int k = 0; k <= 8; k++) begin
            drive(k, 0, 1, 32'd10);
            if (k == 1) begin
                checks++; if (idle !== 1'b0) begin errors++; $display("FAIL single_idle_inflight: got %b expected 0", idle); end
            end
            if (k < 8) begin
                checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_early_valid c%0d: got %b expected 0", k, out_valid); end
            end else begin
                checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL single_valid: got %b expected 1", out_valid); end
                checks++; if (out_vec !== exp_row(0, 32'd10)) begin errors++; $display("FAIL single_vec: got %h expected %h", out_vec, exp_row(0, 32'd10)); end
                checks++; if (count !== 4'd1) begin errors++; $display("FAIL single_count: got %0d expected 1", count); end
                checks++; if (idle !== 1'b0) begin errors++; $display("FAIL single_idle: got %b expected 0", idle); end
            end
            tick();
        end
        out_ready = 1'b1;
        drive(9, 0, 1, 32'd10);
        tick();
        out_ready = 1'b0;
        checks++; if (count !== 4'd0) begin errors++; $display("FAIL single_drain_count: got %0d expected 0", count); end
        checks++; if (idle !== 1'b1) begin errors++; $display("FAIL single_drain_idle: got %b expected 1", idle); end
    endtask

    task automatic test_streaming();
        logic exp_v;
        reset_dut();
        out_ready = 1'b1;
        for (int k = 0; k <= 14; k++) begin
            drive(k, 0, 4, 32'd0);
            exp_v = (k >= 8) && (k <= 11);
            checks++; if (out_valid !== exp_v) begin errors++; $display("FAIL stream_valid c%0d: got %b expected %b", k, out_valid, exp_v); end
            if (exp_v) begin
                checks++; if (out_vec !== exp_row(k-8, 32'd0)) begin errors++; $display("FAIL stream_vec c%0d: got %h expected %h", k, out_vec, exp_row(k-8, 32'd0)); end
            end
            checks++; if (count > 4'd1) begin errors++; $display("FAIL stream_count c%0d: got %0d expected <=1", k, count); end
            if (k >= 12) begin
                checks++; if (idle !== 1'b1) begin errors++; $display("FAIL stream_idle c%0d: got %b expected 1", k, idle); end
            end
            tick();
        end
        out_ready = 1'b0;
    endtask

    task automatic test_overflow();
        reset_dut();
        out_ready = 1'b0;
        for (int k = 0; k <= 19; k++) begin
            drive(k, 0, 9, 32'h100);
            if (k == 15) begin
                checks++; if (count !== 4'd8) begin errors++; $display("FAIL ovf_full_count: got %0d expected 8", count); end
                checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_early: got %b expected 0", overflow); end
            end
            if (k >= 16) begin
                checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky c%0d: got %b expected 1", k, overflow); end
                checks++; if (count !== 4'd8) begin errors++; $display("FAIL ovf_count c%0d: got %0d expected 8", k, count); end
            end
            tick();
        end
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            drive(20 + i, 0, 9, 32'h100);
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL ovf_drain_valid r%0d: got %b expected 1", i, out_valid); end
            checks++; if (out_vec !== exp_row(i, 32'h100)) begin errors++; $display("FAIL ovf_drain_vec r%0d: got %h expected %h", i, out_vec, exp_row(i, 32'h100)); end
            tick();
        end
        out_ready = 1'b0;
        checks++; if (count !== 4'd0) begin errors++; $display("FAIL ovf_drained_count: got %0d expected 0", count); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL ovf_drained_valid: got %b expected 0", out_valid); end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_after_drain: got %b expected 1", overflow); end
    endtask

    task automatic test_full_push_pop();
        reset_dut();
        for (int k = 0; k <= 24; k++) begin
            out_ready = (k >= 15);
            drive(k, 0, 9, 32'h200);
            if (k == 15) begin
                checks++; if (count !== 4'd8) begin errors++; $display("FAIL fpp_full: got %0d expected 8", count); end
                checks++; if (out_vec !== exp_row(0, 32'h200)) begin errors++; $display("FAIL fpp_head0: got %h expected %h", out_vec, exp_row(0, 32'h200)); end
            end
            if (k == 16) begin
                checks++; if (count !== 4'd8) begin errors++; $display("FAIL fpp_count: got %0d expected 8", count); end
                checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL fpp_overflow: got %b expected 0", overflow); end
            end
            if (k >= 16 && k <= 23) begin
                checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL fpp_valid c%0d: got %b expected 1", k, out_valid); end
                checks++; if (out_vec !== exp_row(k-15, 32'h200)) begin errors++; $display("FAIL fpp_vec c%0d: got %h expected %h", k, out_vec, exp_row(k-15, 32'h200)); end
            end
            if (k == 24) begin
                checks++; if (count !== 4'd0) begin errors++; $display("FAIL fpp_drained: got %0d expected 0", count); end
            end
            tick();
        end
        out_ready = 1'b0;
    endtask

    task automatic test_reset_midflight();
        reset_dut();
        out_ready = 1'b0;
        for (int k = 0; k <= 20; k++) begin
            drive(k, 0, 1, 32'h300);
            if (k == 5) begin
                reset    = 1'b1;
                in_valid = 1'b1;
            end else begin
                reset = 1'b0;
            end
            if (k >= 6) begin
                checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_valid c%0d: got %b expected 0", k, out_valid); end
                checks++; if (count !== 4'd0) begin errors++; $display("FAIL mid_count c%0d: got %0d expected 0", k, count); end
                checks++; if (idle !== 1'b1) begin errors++; $display("FAIL mid_idle c%0d: got %b expected 1", k, idle); end
                checks++; if (out_vec !== 128'd0) begin errors++; $display("FAIL mid_vec c%0d: got %h expected 0", k, out_vec); end
                checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL mid_overflow c%0d: got %b expected 0", k, overflow); end
            end
            tick();
        end
        reset = 1'b0;
    endtask

    task automatic test_stall_hold();
        reset_dut();
        for (int k = 0; k <= 14; k++) begin
            out_ready = (k == 13);
            drive(k, 0, 2, 32'h400);
            if (k >= 8 && k <= 12) begin
                checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL stall_valid c%0d: got %b expected 1", k, out_valid); end
                checks++; if (out_vec !== exp_row(0, 32'h400)) begin errors++; $display("FAIL stall_vec c%0d: got %h expected %h", k, out_vec, exp_row(0, 32'h400)); end
            end
            if (k >= 9 && k <= 13) begin
                checks++; if (count !== 4'd2) begin errors++; $display("FAIL stall_count c%0d: got %0d expected 2", k, count); end
            end
            if (k == 14) begin
                checks++; if (count !== 4'd1) begin errors++; $display("FAIL stall_one_pop: got %0d expected 1", count); end
                checks++; if (out_vec !== exp_row(1, 32'h400)) begin errors++; $display("FAIL stall_next: got %h expected %h", out_vec, exp_row(1, 32'h400)); end
            end
            tick();
        end
        out_ready = 1'b0;
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        ps_in_vec = '0;
        test_reset();
        test_single();
        test_streaming();
        test_overflow();
        test_full_push_pop();
        test_reset_midflight();
        test_stall_hold();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
